branch_resolve: RTL and testbench
=================================

// Module: branch_resolve
// PURPOSE
//  Consumer side of the ALU flag interface: evaluates branch conditions against the registered V/Z/N flags.
//  Computes the branch/jump target and issues a one-cycle PC redirect plus a multi-cycle pipeline flush.
//  Sits in EX beside the ALU. Waits while a flag write from an older instruction is still in flight.
// PARAMETERS
//  FLUSH_CYCLES  2   cycles flush is held high, counted from the redirect cycle (legal range 1..7)
// PORTS
//  clk           in   1   system clock; all state on posedge
//  rst_n         in   1   asynchronous, active-low reset
//  br_valid      in   1   request present this cycle
//  br_ready      out  1   block can accept a request
//  br_kind       in   2   00 cond branch, 01 JAL, 10 JR, 11 reserved (treated as not-taken)
//  br_cond       in   3   condition code (see BEHAVIOUR)
//  pc_plus1      in   16  address of the following instruction
//  br_imm        in   12  offset; branch uses [8:0], JAL uses [11:0]; sign-extended
//  jr_src        in   16  register operand for JR
//  V, Z, N       in   1   registered ALU flags
//  flags_busy    in   1   an older flag-setting instruction writes V/Z/N at the next posedge
//  redirect      out  1   one-cycle pulse: fetch from redirect_pc
//  redirect_pc   out  16  target; valid while redirect=1
//  flush         out  1   squash younger IF/ID instructions
//  resolved      out  1   one-cycle pulse per completed request
//  taken         out  1   outcome; valid with resolved
// BEHAVIOUR
//  Reset: state=IDLE, br_ready=1; redirect, redirect_pc, flush, resolved, taken, flush counter and latched request all 0.
//  Handshake: request accepted on the posedge where br_valid & br_ready. br_ready=1 only in IDLE.
//    br_valid while br_ready=0 is ignored, not queued. Accepting a request latches all request fields.
//  Conditions: 000 NE Z=0 | 001 EQ Z=1 | 010 GT Z=0&N=0 | 011 LT N=1 | 100 GE Z=1|(Z=0&N=0)
//    | 101 LE N=1|Z=1 | 110 OV V=1 | 111 always. JAL and JR are always taken.
//  Targets: branch = pc_plus1 + sext(imm[8:0]); JAL = pc_plus1 + sext(imm[11:0]); JR = jr_src.
//    All target arithmetic is 16 bits, modulo 2^16. No saturation.
//  States:
//    IDLE -> EVAL on accept when flags_busy=0 or the request is JAL/JR.
//    IDLE -> WAIT on accept of a cond branch when flags_busy=1.
//    WAIT: held while flags_busy=1; when flags_busy=0 -> EVAL. Flags are sampled in EVAL, never in WAIT.
//    EVAL (1 cycle): decide the outcome.
//      Not taken: resolved=1, taken=0 at the next edge; -> IDLE.
//      Taken: redirect=1, redirect_pc=target, resolved=1, taken=1, flush=1, counter=FLUSH_CYCLES-1; -> FLUSH.
//    FLUSH: flush=1; counter decrements; leave to IDLE when counter reaches 0.
//      redirect/resolved drop after one cycle. With FLUSH_CYCLES=1, FLUSH lasts 0 extra cycles.
//  Latency (flags_busy=0): outputs registered; redirect is high 2 edges after accept. Each WAIT cycle adds 1.
//  Outputs are registered; none depend combinationally on inputs except br_ready, which is derived from state.
//  Reset mid-WAIT/FLUSH: immediate return to reset values; the in-flight request is dropped.
// CONFIGURATION
//  BRANCH_STATS_EN defined:
//    adds outputs stat_taken[15:0] and stat_not_taken[15:0], reset to 0.
//    Each resolved pulse increments exactly one counter; counters wrap 0xFFFF->0.
//  BRANCH_STATS_EN undefined: these ports and counters do not exist.
// STRUCTURE
//  cpu_pkg: condition-code constants, br_kind constants, state encoding (IDLE/WAIT/EVAL/FLUSH).
//  Sub-module br_cond_eval: combinational (cond, V, Z, N) -> met. Used once; reused by any future predictor check.
// TESTING
//  1. Z=1, cond=001, pc_plus1=0x0010, imm=0x005, flags_busy=0 -> redirect 2 edges after accept, redirect_pc=0x0015, flush 2 cycles.
//  2. Z=0, N=1, cond=010 -> resolved=1, taken=0, no redirect, no flush, br_ready=1 on the next cycle.
//  3. flags_busy=1 for 3 cycles, then flags change to Z=1, cond=001 -> decision uses the updated Z; redirect 3 cycles later than case 1.
//  4. JAL, pc_plus1=0xFFFE, imm=0x003 -> redirect_pc=0x0001 (wrap). JR jr_src=0x1234 -> redirect_pc=0x1234.
//  5. br_valid held high during FLUSH -> br_ready=0 and the request is ignored. The next accept happens only after return to IDLE.
//  6. rst_n low mid-FLUSH -> flush/redirect drop immediately, br_ready=1. With BRANCH_STATS_EN: 3 taken + 2 not-taken -> counters read 3/2.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the branch-resolve block.
//   - condition-code and br_kind encodings
//   - branch FSM state encoding
//   - latched request record and a target-address helper
package cpu_pkg;

    // Condition codes carried in br_cond
    localparam logic [2:0] COND_NE = 3'b000;
    localparam logic [2:0] COND_EQ = 3'b001;
    localparam logic [2:0] COND_GT = 3'b010;
    localparam logic [2:0] COND_LT = 3'b011;
    localparam logic [2:0] COND_GE = 3'b100;
    localparam logic [2:0] COND_LE = 3'b101;
    localparam logic [2:0] COND_OV = 3'b110;
    localparam logic [2:0] COND_AL = 3'b111;

    // Request kinds carried in br_kind
    localparam logic [1:0] KIND_BR  = 2'b00;
    localparam logic [1:0] KIND_JAL = 2'b01;
    localparam logic [1:0] KIND_JR  = 2'b10;
    localparam logic [1:0] KIND_RSV = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_EVAL  = 2'd2,
        ST_FLUSH = 2'd3
    } br_state_t;

    typedef struct packed {
        logic [1:0]  kind;
        logic [2:0]  cond;
        logic [15:0] pc_plus1;
        logic [11:0] imm;
        logic [15:0] jr_src;
    } br_req_t;

    // Target address; all arithmetic wraps modulo 2^16.
    function automatic logic [15:0] br_target(input br_req_t r);
        logic [15:0] t;
        case (r.kind)
            KIND_JAL: t = r.pc_plus1 + {{4{r.imm[11]}}, r.imm};
            KIND_JR:  t = r.jr_src;
            default:  t = r.pc_plus1 + {{7{r.imm[8]}}, r.imm[8:0]};
        endcase
        return t;
    endfunction

endpackage

// File: rtl/br_cond_eval.sv
// Combinational condition evaluator: (cond, V, Z, N) -> met.
// Ports:
//   cond  in  3  condition code
//   V,Z,N in  1  ALU flags
//   met   out 1  condition holds
module br_cond_eval
    import cpu_pkg::*;
(
    input  logic [2:0] cond,
    input  logic       V,
    input  logic       Z,
    input  logic       N,
    output logic       met
);

    always_comb begin
        met = 1'b0;
        case (cond)
            COND_NE: met = ~Z;
            COND_EQ: met = Z;
            COND_GT: met = ~Z & ~N;
            COND_LT: met = N;
            COND_GE: met = Z | (~Z & ~N);
            COND_LE: met = N | Z;
            COND_OV: met = V;
            COND_AL: met = 1'b1;
            default: met = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_resolve.sv
// Branch resolution in EX: evaluates branch conditions on the registered
// V/Z/N flags, computes the target, pulses redirect/resolved and holds flush
// for FLUSH_CYCLES cycles starting with the redirect cycle. A conditional
// branch accepted while an older flag write is in flight parks in WAIT
// until flags_busy drops; flags are only looked at in EVAL.
//
// Ports:
//   clk, rst_n                clock, async active-low reset
//   br_valid / br_ready       request handshake (ready only in IDLE)
//   br_kind, br_cond          request type and condition code
//   pc_plus1, br_imm, jr_src  target operands
//   V, Z, N, flags_busy       ALU flag interface
//   redirect, redirect_pc     one-cycle PC redirect
//   flush                     squash younger IF/ID instructions
//   resolved, taken           one-cycle completion pulse and outcome
//   stat_taken, stat_not_taken  outcome counters (BRANCH_STATS_EN only)
//
// Optional feature: define BRANCH_STATS_EN to add the outcome counters.
module branch_resolve
    import cpu_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        br_valid,
    output logic        br_ready,
    input  logic [1:0]  br_kind,
    input  logic [2:0]  br_cond,
    input  logic [15:0] pc_plus1,
    input  logic [11:0] br_imm,
    input  logic [15:0] jr_src,
    input  logic        V,
    input  logic        Z,
    input  logic        N,
    input  logic        flags_busy,
    output logic        redirect,
    output logic [15:0] redirect_pc,
    output logic        flush,
    output logic        resolved,
`ifdef BRANCH_STATS_EN
    output logic [15:0] stat_taken,
    output logic [15:0] stat_not_taken,
`endif
    output logic        taken
);

    localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES - 1);

    br_state_t   state, state_nxt;
    br_req_t     req;
    logic [2:0]  cnt;
    logic        cond_met;
    logic        go_taken;
    logic        accept;

    br_cond_eval u_cond (
        .cond (req.cond),
        .V    (V),
        .Z    (Z),
        .N    (N),
        .met  (cond_met)
    );

    assign br_ready = (state == ST_IDLE);
    assign accept   = br_ready & br_valid;

    // Jumps always go; reserved kind never does.
    always_comb begin
        go_taken = 1'b0;
        case (req.kind)
            KIND_BR:  go_taken = cond_met;
            KIND_JAL,
            KIND_JR:  go_taken = 1'b1;
            default:  go_taken = 1'b0;
        endcase
    end

    // Only a conditional branch needs the flags, so only it waits on
    // flags_busy; jumps and the reserved kind go straight to EVAL.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (br_valid)
                          state_nxt = (br_kind == KIND_BR && flags_busy) ? ST_WAIT : ST_EVAL;
            ST_WAIT:  if (!flags_busy) state_nxt = ST_EVAL;
            ST_EVAL:  state_nxt = go_taken ? ST_FLUSH : ST_IDLE;
            ST_FLUSH: if (cnt == 3'd0) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // The redirect cycle is the first FLUSH cycle, so the counter is loaded
    // with FLUSH_CYCLES-1 and FLUSH exits when it has run down to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req         <= '0;
            cnt         <= 3'd0;
            redirect    <= 1'b0;
            redirect_pc <= 16'h0000;
            flush       <= 1'b0;
            resolved    <= 1'b0;
            taken       <= 1'b0;
        end else begin
            redirect <= 1'b0;
            resolved <= 1'b0;
            if (accept)
                req <= '{kind: br_kind, cond: br_cond, pc_plus1: pc_plus1,
                         imm: br_imm, jr_src: jr_src};
            case (state)
                ST_EVAL: begin
                    resolved <= 1'b1;
                    taken    <= go_taken;
                    if (go_taken) begin
                        redirect    <= 1'b1;
                        redirect_pc <= br_target(req);
                        flush       <= 1'b1;
                        cnt         <= FLUSH_INIT;
                    end
                end
                ST_FLUSH: begin
                    if (cnt == 3'd0) flush <= 1'b0;
                    else             cnt   <= cnt - 3'd1;
                end
                default: ;
            endcase
        end
    end

`ifdef BRANCH_STATS_EN
    // Counts follow the resolved pulse; both wrap at 16 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_taken     <= 16'h0000;
            stat_not_taken <= 16'h0000;
        end else if (state == ST_EVAL) begin
            if (go_taken) stat_taken     <= stat_taken + 16'h0001;
            else          stat_not_taken <= stat_not_taken + 16'h0001;
        end
    end
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// Self-checking bench for branch_resolve: directed vector table, hand
// sequences for WAIT / held br_valid / reset mid-FLUSH, then random requests
// checked against a behavioural model. Build with BRANCH_STATS_EN defined to
// also check the outcome counters.
module tb_branch_resolve;
    import cpu_pkg::*;

    localparam int FC = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        br_valid;
    logic        br_ready;
    logic [1:0]  br_kind;
    logic [2:0]  br_cond;
    logic [15:0] pc_plus1;
    logic [11:0] br_imm;
    logic [15:0] jr_src;
    logic        V, Z, N;
    logic        flags_busy;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        flush;
    logic        resolved;
    logic        taken;
`ifdef BRANCH_STATS_EN
    logic [15:0] stat_taken, stat_not_taken;
`endif

    branch_resolve #(.FLUSH_CYCLES(FC)) dut (
        .clk(clk), .rst_n(rst_n), .br_valid(br_valid), .br_ready(br_ready),
        .br_kind(br_kind), .br_cond(br_cond), .pc_plus1(pc_plus1),
        .br_imm(br_imm), .jr_src(jr_src), .V(V), .Z(Z), .N(N),
        .flags_busy(flags_busy), .redirect(redirect), .redirect_pc(redirect_pc),
        .flush(flush), .resolved(resolved),
`ifdef BRANCH_STATS_EN
        .stat_taken(stat_taken), .stat_not_taken(stat_not_taken),
`endif
        .taken(taken)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int m_tk     = 0;   // model outcome counts since last reset
    int m_nt     = 0;

    typedef struct {
        logic [1:0]  kind;
        logic [2:0]  cond;
        logic [15:0] pc;
        logic [11:0] imm;
        logic [15:0] jr;
        int          busy;   // cycles flags_busy is high, from the request cycle
        logic [2:0]  fo;     // {V,Z,N} while busy
        logic [2:0]  fn;     // {V,Z,N} once busy has dropped
        bit          et;
        logic [15:0] ep;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference outcome straight from the condition table.
    function automatic bit m_taken(input logic [1:0] k, input logic [2:0] c, input logic [2:0] f);
        bit v, z, n;
        v = f[2]; z = f[1]; n = f[0];
        if (k == 2'd1 || k == 2'd2) return 1'b1;
        if (k == 2'd3) return 1'b0;
        case (c)
            3'd0: return !z;
            3'd1: return z;
            3'd2: return !z && !n;
            3'd3: return n;
            3'd4: return z || (!z && !n);
            3'd5: return n || z;
            3'd6: return v;
            default: return 1'b1;
        endcase
    endfunction

    // Reference target using signed integer arithmetic, reduced mod 2^16.
    function automatic logic [15:0] m_target(input logic [1:0] k, input logic [15:0] pc,
                                             input logic [11:0] imm, input logic [15:0] jr);
        int off;
        int s;
        if (k == 2'd2) return jr;
        if (k == 2'd1) off = (int'(imm) >= 2048) ? int'(imm) - 4096 : int'(imm);
        else           off = (int'(imm[8:0]) >= 256) ? int'(imm[8:0]) - 512 : int'(imm[8:0]);
        s = int'(pc) + off;
        if (s < 0) s += 65536;
        return 16'(s % 65536);
    endfunction

    task automatic do_req(input vec_t t, input string tag);
        int c, lat, k;
        bit seen;
        lat = (t.kind == KIND_BR && t.busy > 0) ? 2 + t.busy : 2;
        @(negedge clk);
        br_valid   = 1'b1;
        br_kind    = t.kind;  br_cond = t.cond;
        pc_plus1   = t.pc;    br_imm  = t.imm;  jr_src = t.jr;
        flags_busy = (t.busy > 0);
        {V, Z, N}  = (t.busy > 0) ? t.fo : t.fn;
        c = 0; seen = 1'b0;
        while (!seen && c < 30) begin
            @(negedge clk);
            c++;
            if (c == 1) begin
                br_valid = 1'b0;
                chk({tag, " accepted"}, br_ready, 0);
            end
            flags_busy = (c < t.busy);
            if (c >= t.busy) {V, Z, N} = t.fn;
            if (resolved) seen = 1'b1;
        end
        chk({tag, " latency"}, c, lat);
        if (!seen) return;
        chk({tag, " taken"}, taken, t.et);
        chk({tag, " redirect"}, redirect, t.et);
        chk({tag, " flush"}, flush, t.et);
        if (t.et) begin
            chk({tag, " redirect_pc"}, redirect_pc, t.ep);
            m_tk++;
            k = 0;
            do begin
                @(negedge clk);
                k++;
                if (k == 1) chk({tag, " pulse drop"}, {redirect, resolved}, 0);
            end while (flush && k < 12);
            chk({tag, " flush cycles"}, k, FC);
        end else begin
            m_nt++;
        end
        chk({tag, " ready after"}, br_ready, 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        m_tk = 0; m_nt = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    vec_t vt[14];
    vec_t r;
    int   seq_res[$];
    logic [15:0] seq_pc[$];
    int   ready_early;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0]  = '{KIND_BR,  COND_EQ, 16'h0010, 12'h005, 16'h0000, 0, 3'b000, 3'b010, 1'b1, 16'h0015};
        vt[1]  = '{KIND_BR,  COND_GT, 16'h0020, 12'h004, 16'h0000, 0, 3'b000, 3'b001, 1'b0, 16'h0000};
        vt[2]  = '{KIND_BR,  COND_EQ, 16'h0200, 12'h010, 16'h0000, 3, 3'b000, 3'b010, 1'b1, 16'h0210};
        vt[3]  = '{KIND_JAL, COND_NE, 16'hFFFE, 12'h003, 16'h0000, 0, 3'b010, 3'b010, 1'b1, 16'h0001};
        vt[4]  = '{KIND_JR,  COND_NE, 16'h0040, 12'h000, 16'h1234, 0, 3'b010, 3'b010, 1'b1, 16'h1234};
        vt[5]  = '{KIND_BR,  COND_NE, 16'h0100, 12'hDF0, 16'h0000, 0, 3'b000, 3'b000, 1'b1, 16'h00F0};
        vt[6]  = '{KIND_JAL, COND_EQ, 16'h0000, 12'h800, 16'h0000, 0, 3'b000, 3'b000, 1'b1, 16'hF800};
        vt[7]  = '{KIND_BR,  COND_OV, 16'h1000, 12'h0FF, 16'h0000, 0, 3'b000, 3'b100, 1'b1, 16'h10FF};
        vt[8]  = '{KIND_BR,  COND_OV, 16'h1000, 12'h0FF, 16'h0000, 0, 3'b000, 3'b011, 1'b0, 16'h0000};
        vt[9]  = '{KIND_BR,  COND_GE, 16'h0030, 12'h002, 16'h0000, 0, 3'b000, 3'b001, 1'b0, 16'h0000};
        vt[10] = '{KIND_BR,  COND_LE, 16'h0050, 12'h1FF, 16'h0000, 0, 3'b000, 3'b010, 1'b1, 16'h004F};
        vt[11] = '{KIND_BR,  COND_AL, 16'hFFFF, 12'h001, 16'h0000, 0, 3'b000, 3'b000, 1'b1, 16'h0000};
        vt[12] = '{KIND_RSV, COND_AL, 16'h0060, 12'h001, 16'h5555, 0, 3'b000, 3'b111, 1'b0, 16'h0000};
        vt[13] = '{KIND_BR,  COND_LT, 16'h0070, 12'h008, 16'h0000, 1, 3'b001, 3'b000, 1'b0, 16'h0000};

        rst_n = 1'b0; br_valid = 1'b0; br_kind = 2'd0; br_cond = 3'd0;
        pc_plus1 = 16'h0; br_imm = 12'h0; jr_src = 16'h0;
        V = 1'b0; Z = 1'b0; N = 1'b0; flags_busy = 1'b0;
        #12;
        chk("reset br_ready", br_ready, 1);
        chk("reset outputs", {redirect, flush, resolved, taken}, 0);
        chk("reset redirect_pc", redirect_pc, 0);
`ifdef BRANCH_STATS_EN
        chk("reset stats", {stat_taken, stat_not_taken}, 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors
        foreach (vt[i]) do_req(vt[i], $sformatf("vec%0d", i));

        // br_valid held through FLUSH: second request accepted only in IDLE
        @(negedge clk);
        br_valid = 1'b1; br_kind = KIND_BR; br_cond = COND_EQ;
        pc_plus1 = 16'h0100; br_imm = 12'h020; jr_src = 16'h0000;
        {V, Z, N} = 3'b010; flags_busy = 1'b0;
        ready_early = 0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (c == 1) begin
                br_kind = KIND_JR; jr_src = 16'h4444;
            end
            if (c <= 1 + FC && br_ready) ready_early++;
            if (resolved) begin
                seq_res.push_back(c);
                seq_pc.push_back(redirect_pc);
            end
            if (c == 3 + FC) br_valid = 1'b0;
        end
        m_tk += 2;
        chk("hold ready low", ready_early, 0);
        chk("hold resolve count", seq_res.size(), 2);
        if (seq_res.size() == 2) begin
            chk("hold first cycle", seq_res[0], 2);
            chk("hold first pc", seq_pc[0], 16'h0120);
            chk("hold second cycle", seq_res[1], 4 + FC);
            chk("hold second pc", seq_pc[1], 16'h4444);
        end

        // Counter sequence from a clean reset: 3 taken, 2 not taken
        do_reset();
        do_req(vt[0], "st0");
        do_req(vt[1], "st1");
        do_req(vt[4], "st2");
        do_req(vt[8], "st3");
        do_req(vt[3], "st4");
`ifdef BRANCH_STATS_EN
        chk("stats taken 3", stat_taken, 3);
        chk("stats not taken 2", stat_not_taken, 2);
`endif

        // Reset asserted mid-FLUSH
        @(negedge clk);
        br_valid = 1'b1; br_kind = KIND_JAL; pc_plus1 = 16'h0400; br_imm = 12'h010;
        flags_busy = 1'b0;
        @(negedge clk);
        br_valid = 1'b0;
        @(negedge clk);
        chk("midflush flush high", flush, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("midflush reset outputs", {flush, redirect, resolved, taken}, 0);
        chk("midflush reset ready", br_ready, 1);
`ifdef BRANCH_STATS_EN
        chk("midflush reset stats", {stat_taken, stat_not_taken}, 0);
`endif
        m_tk = 0; m_nt = 0;
        @(negedge clk);
        rst_n = 1'b1;

        // Random requests against the model
        for (int i = 0; i < 40; i++) begin
            r.kind = 2'($urandom_range(0, 3));
            r.cond = 3'($urandom_range(0, 7));
            r.pc   = 16'($urandom);
            r.imm  = 12'($urandom);
            r.jr   = 16'($urandom);
            r.busy = $urandom_range(0, 3);
            r.fo   = 3'($urandom);
            r.fn   = 3'($urandom);
            r.et   = m_taken(r.kind, r.cond, r.fn);
            r.ep   = m_target(r.kind, r.pc, r.imm, r.jr);
            do_req(r, $sformatf("rnd%0d", i));
        end
`ifdef BRANCH_STATS_EN
        chk("rnd stats taken", stat_taken, 16'(m_tk));
        chk("rnd stats not taken", stat_not_taken, 16'(m_nt));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
